// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor sequencer: diff = a - b, LSB first,
// one bit per clock through a single 1-bit subtract cell.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bin_q, bin_d;
   logic             borrow_q, borrow_d;

   logic hs1_d, hs1_b, hs2_b;
   logic d_bit, bout;

   // 1-bit subtract cell: two half subtractors chained through the borrow
   always_comb begin
      hs1_d = sa_q[0] ^ sb_q[0];
      hs1_b = ~sa_q[0] & sb_q[0];
      d_bit = hs1_d ^ bin_q;
      hs2_b = ~hs1_d & bin_q;
      bout  = hs1_b | hs2_b;
   end

   // Sequencer: capture, shift one bit per cycle, publish on last bit
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      res_d    = res_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      borrow_d = borrow_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               bin_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            res_d = {d_bit, res_q[WIDTH-1:1]};
            sa_d  = {1'b0, sa_q[WIDTH-1:1]};
            sb_d  = {1'b0, sb_q[WIDTH-1:1]};
            bin_d = bout;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               diff_d   = {d_bit, res_q[WIDTH-1:1]};
               borrow_d = bout;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, all cleared by async reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         bin_q    <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         borrow_q <= borrow_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8): expected
// results queued at start, popped and compared on done.
module tb_serial_sub_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow;

   logic [8:0] sb[$];
   logic [8:0] e;
   int         n_vec;
   int         n_err;
   int         n;

   serial_sub_ctrl #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] model(input logic [7:0] x,
                                        input logic [7:0] y);
      logic [8:0] t;
      t = {1'b0, x} - {1'b0, y};
      return {(x < y), t[7:0]};
   endfunction

   task automatic op(input logic [7:0] x, input logic [7:0] y,
                     input bit push);
      @(negedge clk);
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (push) sb.push_back(model(x, y));
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!done && cnt < 40);
      if (!done) chk("timeout", 0, 1);
   endtask

   // Monitor: every done pulse must match the oldest queued result
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            chk("spur_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("diff", diff, e[7:0]);
            chk("borrow", borrow, e[8]);
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      op(8'h05, 8'h03, 1);
      @(negedge clk);
      chk("busy_rise", busy, 1);
      chk("done_early", done, 0);
      wait_done(n);
      chk("latency", n, 8);
      @(negedge clk);
      chk("busy_fall", busy, 0);
      chk("done_len", done, 0);

      op(8'h03, 8'h05, 1);
      wait_done(n);
      op(8'h00, 8'hFF, 1);
      wait_done(n);
      op(8'hA5, 8'hA5, 1);
      wait_done(n);
      op(8'hFF, 8'h00, 1);
      wait_done(n);
      chk("lat_full", n, 9);

      op(8'h10, 8'h01, 1);
      @(negedge clk);
      @(negedge clk);
      a     = 8'h00;
      b     = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("lat_ignore", n, 6);
      repeat (6) @(negedge clk);
      chk("hold_diff", diff, 8'h0F);
      chk("hold_borrow", borrow, 0);
      chk("idle_busy", busy, 0);

      op(8'h44, 8'h11, 0);
      repeat (3) @(negedge clk);
      chk("hold_run", diff, 8'h0F);
      @(negedge clk);
      chk("busy_mid", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_diff", diff, 0);
      chk("arst_borrow", borrow, 0);
      repeat (2) begin
         @(negedge clk);
         chk("arst_nodone", done, 0);
      end
      rst_n = 1'b1;
      op(8'h20, 8'h01, 1);
      wait_done(n);
      chk("lat_post_rst", n, 9);

      @(negedge clk);
      repeat (3) sb.push_back(model(8'h09, 8'h04));
      a     = 8'h09;
      b     = 8'h04;
      start = 1'b1;
      wait_done(n);
      chk("held_first", n, 9);
      wait_done(n);
      chk("held_period", n, 10);
      wait_done(n);
      chk("held_period", n, 10);
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("held_stop", busy, 0);
      chk("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
